// File: rtl/mux_nto1_scan_pkg.sv
// Shared types and helpers for the N-to-1 scan selector (package mux_pkg).
package mux_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SCAN = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam logic MODE_DIRECT = 1'b0;
  localparam logic MODE_SCAN   = 1'b1;

  // Bit offset of channel idx inside the packed in_data vector.
  function automatic int unsigned ch_lsb(input int unsigned idx, input int unsigned w);
    return idx * w;
  endfunction

endpackage

// File: rtl/mux_nto1_scan_if.sv
// Bus bundle for mux_nto1_scan: channel inputs, controls and the handshaked output word.
interface mux_nto1_scan_if #(
  parameter int N_CH  = 32,
  parameter int W     = 1,
  parameter int SEL_W = $clog2(N_CH)
);

  logic [N_CH*W-1:0] in_data;
  logic [SEL_W-1:0]  sel;
  logic              en;
  logic              mode;
  logic              start_scan;
  logic              out_ready;
  logic [W-1:0]      out_data;
  logic [SEL_W-1:0]  out_sel;
  logic              out_valid;
  logic              sel_err;
  logic              scan_busy;
  logic              scan_done;

  // Output handshake: a word transfers on a rising edge where out_valid && out_ready;
  // while out_valid && !out_ready, out_data/out_sel/sel_err stay stable.
  modport master (
    output in_data, sel, en, mode, start_scan, out_ready,
    input  out_data, out_sel, out_valid, sel_err, scan_busy, scan_done
  );

  modport slave (
    input  in_data, sel, en, mode, start_scan, out_ready,
    output out_data, out_sel, out_valid, sel_err, scan_busy, scan_done
  );

endinterface

// File: rtl/mux_nto1_scan_scan_ctr.sv
// Sweep counter for the scan selector; wraps at N_CH-1 when MUX_SCAN_CONT_EN is defined.
module scan_ctr #(
  parameter int N_CH  = 32,
  parameter int SEL_W = $clog2(N_CH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             adv,
  output logic [SEL_W-1:0] cnt,
  output logic             tc
);

  localparam logic [SEL_W-1:0] LAST = SEL_W'(N_CH - 1);

  assign tc = (cnt == LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (adv) begin
      if (!tc) begin
        cnt <= cnt + SEL_W'(1);
      end
`ifdef MUX_SCAN_CONT_EN
      else begin
        cnt <= '0;
      end
`endif
    end
  end

endmodule

// File: rtl/mux_nto1_scan.sv
// Registered N-to-1 channel selector with valid/ready output and auto-scan sweep.
// Optional continuous scan is selected with the MUX_SCAN_CONT_EN macro.
module mux_nto1_scan
  import mux_pkg::*;
#(
  parameter int N_CH  = 32,
  parameter int W     = 1,
  parameter int SEL_W = $clog2(N_CH)
) (
  input  logic   clk,
  input  logic   rst,
  mux_nto1_scan_if.slave bus,
  output state_t dbg_state
);

  state_t           state, state_n;
  logic [SEL_W-1:0] cnt;
  logic             tc;
  logic             clr, adv;
  logic             load;
  logic             cap_scan, cap_dir;
  logic             done_n;
  logic             sel_ok;
  logic             scan_exit;
  logic [W-1:0]     ch [N_CH];

  for (genvar k = 0; k < N_CH; k++) begin : g_ch
    assign ch[k] = bus.in_data[ch_lsb(k, W) +: W];
  end

  assign load          = !bus.out_valid || bus.out_ready;
  assign sel_ok        = (int'(bus.sel) < N_CH);
  assign bus.scan_busy = (state == S_SCAN);
  assign dbg_state     = state;

`ifdef MUX_SCAN_CONT_EN
  assign scan_exit = !bus.en || (bus.mode == MODE_DIRECT);
`else
  assign scan_exit = !bus.en;
`endif

  scan_ctr #(.N_CH(N_CH), .SEL_W(SEL_W)) u_ctr (
    .clk (clk),
    .rst (rst),
    .clr (clr),
    .adv (adv),
    .cnt (cnt),
    .tc  (tc)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n  = state;
    clr      = 1'b0;
    adv      = 1'b0;
    cap_scan = 1'b0;
    cap_dir  = 1'b0;
    done_n   = 1'b0;
    case (state)
      S_IDLE: begin
        if (bus.start_scan && bus.en && bus.mode == MODE_SCAN) begin
          state_n = S_SCAN;
          clr     = 1'b1;
        end else if (bus.en && bus.mode == MODE_DIRECT && load) begin
          cap_dir = 1'b1;
        end
      end
      S_SCAN: begin
        // Abort keeps any pending word: no capture, so the held word waits for load.
        if (scan_exit) begin
          state_n = S_IDLE;
          clr     = 1'b1;
        end else if (load) begin
          cap_scan = 1'b1;
          adv      = 1'b1;
          if (tc) begin
            done_n = 1'b1;
`ifndef MUX_SCAN_CONT_EN
            state_n = S_DONE;
`endif
          end
        end
      end
      S_DONE: begin
        state_n = S_IDLE;
        clr     = 1'b1;
      end
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.out_data  <= '0;
      bus.out_sel   <= '0;
      bus.out_valid <= 1'b0;
      bus.sel_err   <= 1'b0;
      bus.scan_done <= 1'b0;
    end else begin
      bus.scan_done <= done_n;
      if (cap_scan) begin
        bus.out_data  <= ch[cnt];
        bus.out_sel   <= cnt;
        bus.out_valid <= 1'b1;
        bus.sel_err   <= 1'b0;
      end else if (cap_dir) begin
        bus.out_data  <= sel_ok ? ch[bus.sel] : '0;
        bus.out_sel   <= bus.sel;
        bus.out_valid <= 1'b1;
        bus.sel_err   <= !sel_ok;
      end else if (load) begin
        bus.out_data  <= '0;
        bus.out_sel   <= '0;
        bus.out_valid <= 1'b0;
        bus.sel_err   <= 1'b0;
      end
    end
  end

endmodule

// File: doc/mux_nto1_scan.md
Name: mux_nto1_scan

Overview:
Parametrised, registered N-to-1 channel selector with enable. It is the successor to the fixed 32:1 enable mux in the datapath. It adds a valid/ready output handshake, a registered output stage, and an auto-scan mode that sweeps every channel in order. It sits between the register/flag bus and downstream consumers such as the debug/trace port and the sequential test readout.

Parameters:
N_CH, 32, number of input channels (2..256)
W, 1, width of each channel in bits
SEL_W, $clog2(N_CH), select/counter width (derived; do not override)

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous, active-high reset
in_data  in  N_CH*W  packed channels; channel k = in_data[k*W +: W]
sel  in  SEL_W  channel select, direct mode
en  in  1  block enable
mode  in  1  0 = direct, 1 = scan
start_scan  in  1  single-cycle pulse; starts a sweep in scan mode
out_ready  in  1  downstream accepts the output word
out_data  out  W  registered selected channel
out_sel  out  SEL_W  channel index belonging to out_data
out_valid  out  1  out_data/out_sel valid
sel_err  out  1  registered; captured index >= N_CH
scan_busy  out  1  FSM in SCAN
scan_done  out  1  one-cycle pulse at sweep end

Behaviour:
- Reset (async, immediate): all outputs 0, FSM IDLE, scan counter 0.
- Load condition: load = !out_valid || out_ready. The output register updates only when load is 1. It holds while out_valid && !out_ready.
- Direct mode (mode=0, FSM IDLE):
  - If en && load, then on the next edge: out_data = channel[sel], out_sel = sel, out_valid = 1. Latency is 1 cycle.
  - If sel >= N_CH (non-power-of-2 N_CH only): out_data = 0, sel_err = 1, out_valid = 1. Otherwise sel_err = 0.
  - If !en && load: out_valid = 0 and out_data = 0 (matches legacy "disabled => 0").
- Scan FSM states: IDLE, SCAN, DONE.
  - IDLE -> SCAN: start_scan && en && mode=1. Counter is cleared to 0.
  - SCAN, on each edge with load: capture channel[cnt], out_sel = cnt, out_valid = 1.
    - If cnt == N_CH-1, go to DONE. Otherwise cnt++.
    - Backpressure (!load) stalls the counter. No channel is skipped or duplicated.
  - DONE: scan_done = 1 for exactly one cycle, then IDLE. The final word stays valid until accepted.
  - SCAN with !en: abort to IDLE, counter cleared, scan_done not pulsed. A pending valid word is held until accepted (never dropped).
- start_scan while in SCAN or DONE is ignored.
- mode toggled during SCAN is ignored until IDLE is reached.
- Direct-mode loads are suppressed while FSM != IDLE.
- start_scan with mode=0 is ignored.
- Sweep throughput with out_ready held high: N_CH words in N_CH consecutive cycles. scan_done is asserted in the cycle after the last word is captured.
- in_data is sampled at the capture edge only. Changes while a word is held do not alter out_data.

Optional Feature:
MUX_SCAN_CONT_EN
- Defined: continuous scan. In SCAN, cnt == N_CH-1 wraps to 0 and the FSM stays in SCAN. scan_done pulses for one cycle on every wrap. Exit is on !en or mode=0, which returns to IDLE with the counter cleared and a pending word kept.
- Undefined: single sweep exactly as described under Behaviour. DONE is reachable only via a completed sweep.

Decomposition:
- Package mux_pkg:
  - state enum {S_IDLE, S_SCAN, S_DONE}
  - constants MODE_DIRECT = 1'b0, MODE_SCAN = 1'b1
  - helper function for channel slicing by index
- One sub-module, scan_ctr: SEL_W-bit counter with clear, stall, and terminal-count output at N_CH-1, plus wrap behaviour under MUX_SCAN_CONT_EN.
- The FSM and the output register stay in mux_nto1_scan.

Test Plan:
1. Reset mid-sweep: N_CH=32, W=1, scan running at cnt=10, rst pulsed asynchronously off-edge -> all outputs 0 immediately; IDLE; next start_scan restarts at out_sel=0.
2. Direct mode: W=8, channel 5 = 8'hA5, sel=5, en=1, out_ready=1 -> next cycle out_data=8'hA5, out_sel=5, out_valid=1. Then en=0 -> following cycle out_valid=0, out_data=0.
3. Full sweep: in_data[k]=k (W=8), out_ready=1, start_scan pulse -> out_sel/out_data 0..31 on 32 consecutive cycles; scan_done for 1 cycle after word 31; scan_busy high for 32 cycles.
4. Backpressure: out_ready=0 for 3 cycles at cnt=7 -> out_data/out_sel hold 7; resume yields 8 next with no gap or duplicate; total words 32.
5. Abort: en dropped with word 12 valid and out_ready=0 -> word 12 held until out_ready=1; FSM IDLE; no scan_done; no word 13.
6. N_CH=20, sel=25, direct mode -> out_data=0, sel_err=1, out_valid=1. With MUX_SCAN_CONT_EN: sweep shows out_sel 19 then 0, with scan_done on the wrap.
